// File: rtl/serial_subtractor5.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock from the LSB, Start/Busy/Done handshake.
// Optional signed-overflow output Ovf is built only when SUB_OVERFLOW_EN is defined.
module serial_subtractor5 #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] shifted;
`ifdef SUB_OVERFLOW_EN
  logic             amsb;
  logic             bmsb;
`endif

  // On the last bit, shifted already holds the complete result, so Diff loads it on the same edge.
  always_comb begin
    d       = ra[0] ^ rb[0] ^ br;
    br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    shifted = {d, res};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            ra    <= A;
            rb    <= B;
            br    <= Bin;
            cnt   <= '0;
            res   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
`ifdef SUB_OVERFLOW_EN
            amsb  <= A[WIDTH-1];
            bmsb  <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          br  <= br_next;
          res <= shifted[WIDTH-1:1];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            Diff  <= shifted;
            Bout  <= br_next;
            Done  <= 1'b1;
`ifdef SUB_OVERFLOW_EN
            Ovf   <= (amsb != bmsb) && (d != amsb);
`endif
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor5.sv
// Self-checking bench for serial_subtractor5: cycle-accurate arithmetic model plus directed literal checks.
module tb_serial_subtractor5;
  localparam int unsigned W = 5;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         Busy, Done, Bout;
  logic [W-1:0] Diff;
`ifdef SUB_OVERFLOW_EN
  logic         Ovf;
`endif

  serial_subtractor5 #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout)
`ifdef SUB_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since acceptance; result from plain wide arithmetic.
  int unsigned  age = 0;
  bit           armed = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_bout = 0, p_bout = 0, m_ovf = 0, p_ovf = 0;

  always @(posedge Clk) begin
    logic [W:0] t;
    if (Reset) begin
      armed = 1; age = 0;
      m_diff = '0; m_bout = 0; m_ovf = 0;
    end else if (age == 0) begin
      if (Start) begin
        t = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, Bin};
        p_diff = t[W-1:0];
        p_bout = t[W];
        p_ovf = (A[W-1] != B[W-1]) && (p_diff[W-1] != A[W-1]);
        age = 1;
      end
    end else begin
      age++;
      if (age == W + 1) begin
        m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
      end else if (age == W + 2) begin
        age = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("busy", Busy, (age != 0));
      check("done", Done, (age == W + 1));
      check("diff", Diff, m_diff);
      check("bout", Bout, m_bout);
`ifdef SUB_OVERFLOW_EN
      check("ovf", Ovf, m_ovf);
`endif
    end
  end

  // Issue one op, scramble the operands after acceptance, wait until back in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    @(negedge Clk);
    A = a; B = b; Bin = bi; Start = 1;
    @(negedge Clk);
    Start = 0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    repeat (W + 1) @(negedge Clk);
  endtask

  initial begin
    logic [W-1:0] lo_diff;
    logic         lo_bout;
    bit           seen;

    repeat (2) @(negedge Clk);
    check("reset_busy", Busy, 0);
    check("reset_diff", Diff, 0);
    Reset = 0;

    run_op(5'd9, 5'd3, 1'b0);
    check("t1_diff", Diff, 6);
    check("t1_bout", Bout, 0);
    run_op(5'd3, 5'd9, 1'b0);
    check("t2a_diff", Diff, 26);
    check("t2a_bout", Bout, 1);
    run_op(5'd0, 5'd0, 1'b1);
    check("t2b_diff", Diff, 31);
    check("t2b_bout", Bout, 1);
    run_op(5'd31, 5'd31, 1'b1);
    check("t2c_diff", Diff, 31);
    check("t2c_bout", Bout, 1);

    // Start held high; A changes two cycles after acceptance.
    @(negedge Clk);
    A = 5'd9; B = 5'd3; Bin = 0; Start = 1;
    repeat (2) @(negedge Clk);
    A = 5'd20;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1;
    end
    check("t3_done_seen", seen, 1);
    check("t3_diff", Diff, 6);
    repeat (2 * W + 4) @(negedge Clk);
    check("t3_second_diff", Diff, 17);
    Start = 0;
    repeat (W + 2) @(negedge Clk);

    // Reset in the middle of RUN.
    A = 5'd20; B = 5'd7; Bin = 0; Start = 1;
    @(negedge Clk);
    Start = 0;
    repeat (3) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    check("t4_busy", Busy, 0);
    check("t4_diff", Diff, 0);
    check("t4_bout", Bout, 0);
    repeat (W + 3) @(negedge Clk);

`ifdef SUB_OVERFLOW_EN
    run_op(5'd15, 5'd16, 1'b0);
    check("t5a_diff", Diff, 31);
    check("t5a_bout", Bout, 1);
    check("t5a_ovf", Ovf, 1);
    run_op(5'd5, 5'd3, 1'b0);
    check("t5b_ovf", Ovf, 0);
`endif

    // 10-bit 300 - 45 as two chained words through the same unit.
    run_op(5'(300 % 32), 5'(45 % 32), 1'b0);
    lo_diff = Diff; lo_bout = Bout;
    check("t6_lo_diff", lo_diff, 31);
    check("t6_lo_bout", lo_bout, 1);
    run_op(5'(300 / 32), 5'(45 / 32), lo_bout);
    check("t6_hi_diff", Diff, 7);
    check("t6_combined", {Diff, lo_diff}, 255);

    // Random traffic, including Start during Busy and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      Start = ($urandom_range(0, 2) == 0);
      Reset = ($urandom_range(0, 79) == 0);
    end
    @(negedge Clk);
    Reset = 0; Start = 0;
    repeat (W + 3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
